// File: rtl/stream_fork_reg_if.sv
// Handshake bundle for stream_fork_reg: one input stream and NumStreams output streams.
interface stream_fork_reg_if #(
    parameter int NumStreams = 2,
    parameter int DataWidth  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DataWidth-1:0]  in_data;
    logic [NumStreams-1:0] in_mask;
    logic [NumStreams-1:0] out_valid;
    logic [NumStreams-1:0] out_ready;
    logic [DataWidth-1:0]  out_data;
    logic                  busy;

    // Environment side: produces the input beat, consumes the outputs.
    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Fork side.
    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/stream_fork_reg.sv
// Registered eager fork: one input beat is replicated to the outputs selected
// by its mask; each output drains on its own, and the shared data register
// reloads once every pending output is empty or draining.

// One output slot's pending flag.
module stream_fork_slot (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic load,
    input  logic drain,
    output logic pend
);
    // A new beat overrides a same-cycle drain; otherwise clear on transfer.
    always_ff @(posedge clk) begin
        if (rst)
            pend <= 1'b0;
        else if (accept)
            pend <= load;
        else if (drain)
            pend <= 1'b0;
    end
endmodule

module stream_fork_reg #(
    parameter int NumStreams = 2,
    parameter int DataWidth  = 8
) (
    input logic              clk,
    input logic              rst,
    stream_fork_reg_if.slave bus
);
    logic [NumStreams-1:0] pend;
    logic [DataWidth-1:0]  data_q;
    logic                  accept;

    // Reload allowed only when no slot would be left holding an undelivered beat.
    assign bus.in_ready  = &(~pend | bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = pend;
    assign bus.out_data  = data_q;
    assign bus.busy      = |pend;

    // Payload register shared by all outputs; loads on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst)
            data_q <= '0;
        else if (accept)
            data_q <= bus.in_data;
    end

    for (genvar i = 0; i < NumStreams; i++) begin : g_slot
        stream_fork_slot u_slot (
            .clk    (clk),
            .rst    (rst),
            .accept (accept),
            .load   (bus.in_mask[i]),
            .drain  (bus.out_ready[i]),
            .pend   (pend[i])
        );
    end
endmodule

// File: tb/tb_stream_fork_reg.sv
// Bench for stream_fork_reg: directed scenarios plus a randomized run scored
// against per-output queues of expected beats.
module tb_stream_fork_reg;
    localparam int NS = 2;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    stream_fork_reg_if #(.NumStreams(NS), .DataWidth(DW)) bus ();

    stream_fork_reg #(.NumStreams(NS), .DataWidth(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mask   = '0;
        bus.out_ready = '1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 00", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        tick();
    endtask

    task automatic test_broadcast();
        logic [DW-1:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        bus.out_ready = 2'b11;
        bus.in_mask   = 2'b11;
        for (int k = 0; k <= 3; k++) begin
            bus.in_valid = (k < 3);
            bus.in_data  = (k < 3) ? beats[k] : 8'h00;
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_in_ready[%0d]: got %b expected 1", k, bus.in_ready); end
            if (k > 0) begin
                n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL bcast_valid[%0d]: got %b expected 11", k, bus.out_valid); end
                n_checks++; if (bus.out_data !== beats[k-1]) begin n_fail++; $display("FAIL bcast_data[%0d]: got %h expected %h", k, bus.out_data, beats[k-1]); end
            end
            tick();
        end
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL bcast_drained: got %b expected 00", bus.out_valid); end
    endtask

    task automatic test_eager_stall();
        logic [NS-1:0] rdy_seq [4];
        logic [NS-1:0] vld_seq [4];
        logic          irdy_seq [4];
        int            out0_seen = 0;
        rdy_seq[0] = 2'b01; rdy_seq[1] = 2'b01; rdy_seq[2] = 2'b01; rdy_seq[3] = 2'b10;
        vld_seq[0] = 2'b11; vld_seq[1] = 2'b10; vld_seq[2] = 2'b10; vld_seq[3] = 2'b10;
        irdy_seq[0] = 1'b0; irdy_seq[1] = 1'b0; irdy_seq[2] = 1'b0; irdy_seq[3] = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hA5;
        bus.in_mask   = 2'b11;
        bus.out_ready = 2'b01;
        tick();
        bus.in_data = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            bus.out_ready = rdy_seq[k];
            #1;
            n_checks++; if (bus.out_valid !== vld_seq[k]) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected %b", k, bus.out_valid, vld_seq[k]); end
            n_checks++; if (bus.out_data !== 8'hA5) begin n_fail++; $display("FAIL stall_data[%0d]: got %h expected a5", k, bus.out_data); end
            n_checks++; if (bus.in_ready !== irdy_seq[k]) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected %b", k, bus.in_ready, irdy_seq[k]); end
            if (bus.out_valid[0] && bus.out_ready[0] && bus.out_data == 8'hA5) out0_seen++;
            tick();
        end
        bus.in_valid = 1'b0;
        #1;
        n_checks++; if (out0_seen != 1) begin n_fail++; $display("FAIL stall_out0_once: got %0d transfers expected 1", out0_seen); end
        n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL stall_next_valid: got %b expected 11", bus.out_valid); end
        n_checks++; if (bus.out_data !== 8'h5A) begin n_fail++; $display("FAIL stall_next_data: got %h expected 5a", bus.out_data); end
        bus.out_ready = 2'b11;
        tick();
    endtask

    task automatic test_subset_drop();
        logic [DW-1:0] d [3];
        logic [NS-1:0] m [3];
        d[0] = 8'h01; m[0] = 2'b10;
        d[1] = 8'h02; m[1] = 2'b00;
        d[2] = 8'h03; m[2] = 2'b01;
        bus.out_ready = 2'b11;
        for (int k = 0; k <= 3; k++) begin
            bus.in_valid = (k < 3);
            bus.in_data  = (k < 3) ? d[k] : 8'h00;
            bus.in_mask  = (k < 3) ? m[k] : 2'b00;
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL subset_in_ready[%0d]: got %b expected 1", k, bus.in_ready); end
            if (k > 0) begin
                n_checks++; if (bus.out_valid !== m[k-1]) begin n_fail++; $display("FAIL subset_valid[%0d]: got %b expected %b", k, bus.out_valid, m[k-1]); end
                n_checks++; if (bus.out_data !== d[k-1]) begin n_fail++; $display("FAIL subset_data[%0d]: got %h expected %h", k, bus.out_data, d[k-1]); end
            end
            tick();
        end
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL subset_drained: got %b expected 00", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 2'b00;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h77;
        bus.in_mask   = 2'b11;
        tick();
        bus.in_valid = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 2'b11) begin n_fail++; $display("FAIL rmid_held_valid: got %b expected 11", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_held_in_ready: got %b expected 0", bus.in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_valid: got %b expected 00", bus.out_valid); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", bus.busy); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
        bus.out_ready = 2'b11;
        tick();
        n_checks++; if (bus.out_valid !== 2'b00) begin n_fail++; $display("FAIL rmid_no_redeliver: got %b expected 00", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_q [NS][$];
        logic [NS-1:0] exp_vld, xfer, stall, prev_stall, mask_c;
        logic [DW-1:0] prev_data, data_c;
        logic          exp_rdy, acc;
        int            errs = 0;
        prev_stall = '0;
        prev_data  = '0;
        for (int c = 0; c < 10000; c++) begin
            bus.in_valid = ($urandom_range(0, 1) == 1);
            bus.in_data  = DW'($urandom);
            bus.in_mask  = NS'($urandom_range(0, (1 << NS) - 1));
            for (int i = 0; i < NS; i++) bus.out_ready[i] = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = 1'b1;
            for (int i = 0; i < NS; i++) begin
                exp_vld[i] = (exp_q[i].size() != 0);
                if (exp_vld[i] && !bus.out_ready[i]) exp_rdy = 1'b0;
            end
            if (errs < 10) begin
                n_checks++; if (bus.out_valid !== exp_vld) begin n_fail++; errs++; $display("FAIL rand_valid@%0d: got %b expected %b", c, bus.out_valid, exp_vld); end
                n_checks++; if (bus.busy !== (|exp_vld)) begin n_fail++; errs++; $display("FAIL rand_busy@%0d: got %b expected %b", c, bus.busy, |exp_vld); end
                n_checks++; if (bus.in_ready !== exp_rdy) begin n_fail++; errs++; $display("FAIL rand_in_ready@%0d: got %b expected %b", c, bus.in_ready, exp_rdy); end
                for (int i = 0; i < NS; i++) begin
                    if (exp_vld[i]) begin
                        n_checks++; if (bus.out_data !== exp_q[i][0]) begin n_fail++; errs++; $display("FAIL rand_data%0d@%0d: got %h expected %h", i, c, bus.out_data, exp_q[i][0]); end
                    end
                    if (prev_stall[i]) begin
                        n_checks++; if (bus.out_valid[i] !== 1'b1 || bus.out_data !== prev_data) begin n_fail++; errs++; $display("FAIL rand_hold%0d@%0d: got v=%b d=%h expected v=1 d=%h", i, c, bus.out_valid[i], bus.out_data, prev_data); end
                    end
                end
            end
            acc       = bus.in_valid && exp_rdy;
            xfer      = exp_vld & bus.out_ready;
            stall     = exp_vld & ~bus.out_ready;
            prev_data = bus.out_data;
            data_c    = bus.in_data;
            mask_c    = bus.in_mask;
            @(posedge clk);
            for (int i = 0; i < NS; i++) begin
                if (xfer[i]) void'(exp_q[i].pop_front());
                if (acc && mask_c[i]) exp_q[i].push_back(data_c);
            end
            prev_stall = stall;
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_eager_stall();
        test_subset_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_fork_reg.md
Name: stream_fork_reg

Overview:
- Registered eager fork. Accepts one valid/ready input stream carrying data plus a destination mask, and replicates each accepted beat to a selected subset of NumStreams output streams.
- Each output drains independently. This is the upstream counterpart that splits a stream into parallel branches before a downstream join recombines them.
- All outputs are registered, so there is no combinational path from in_valid or in_data to any output.

Parameters:
- NumStreams, 2, number of output streams (≥1).
- DataWidth, 8, payload width in bits.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid & in_ready.
- in_data  input  DataWidth  input payload.
- in_mask  input  NumStreams  bit i set = deliver beat to output i; sampled with in_data.
- out_valid  output  NumStreams  per-output valid.
- out_ready  input  NumStreams  per-output ready.
- out_data  output  DataWidth  registered payload, shared by all outputs.
- busy  output  1  high while any out_valid bit is set.

Behaviour:
- State:
  - data register D[DataWidth-1:0].
  - pending flags P[NumStreams-1:0], driven as out_valid = P.
  - out_data = D; busy = |P.
- Reset (rst=1 at clock edge):
  - P <= 0, D <= 0.
  - Hence out_valid=0, out_data=0, busy=0 from the first cycle after reset.
  - in_ready is combinational and equals 1 while P=0, so it reads 1 after reset.
  - Reset mid-operation discards all pending beats without delivering them.
- Output transfer on output i: P[i] & out_ready[i].
- in_ready = AND over i of (!P[i] | out_ready[i]). The register may reload only when every slot is empty or drains in the same cycle. This gives full throughput when all selected outputs are ready.
- in_ready never depends on in_valid or in_mask; out_valid never depends on out_ready combinationally.
- Accept (in_valid & in_ready):
  - D <= in_data.
  - P <= in_mask.
  - Overrides any same-cycle drains (those slots were draining anyway).
- No accept: for each i, P[i] <= P[i] & !out_ready[i]. D holds its value.
- Latency: an accepted beat appears on the selected out_valid bits exactly 1 cycle after acceptance.
- Eager semantics:
  - Outputs complete independently.
  - A drained output stays low until the next accepted beat, even while others still hold P[i]=1.
  - A beat is delivered exactly once per selected output.
- in_mask=0: the beat is accepted (consumed and dropped), D updates, P stays 0, and no output sees it.
- Backpressure: while any P[i]=1 with out_ready[i]=0, in_ready=0.
- Data stability: D and P[i] are stable while P[i]=1 and out_ready[i]=0 (AXI-style valid hold).
- out_ready[i] for an output with P[i]=0 has no effect.
- Ordering: beats reach each output in input order. No reordering, no loss other than mask=0 and reset.

Test Plan:
- Reset then idle: assert rst for 2 cycles with out_ready=all 1 -> out_valid=0, out_data=0, busy=0, in_ready=1 on the first cycle after reset.
- Full-rate broadcast (NumStreams=2): in_data=0x11,0x22,0x33 on consecutive cycles, in_mask=2'b11, out_ready=2'b11 -> out_valid=2'b11 with out_data 0x11,0x22,0x33 on cycles 1..3; in_ready=1 throughout.
- Eager drain with stall: accept 0xA5 mask 2'b11; out_ready=2'b01 for 3 cycles then 2'b10 ->
  - out_valid goes 11 -> 10 after the first drain.
  - in_ready=0 until output 1 is ready; the next beat 0x5A loads in that same cycle.
  - Output 0 sees 0xA5 exactly once.
- Subset and drop: beat 0x01 mask 2'b10, then 0x02 mask 2'b00, then 0x03 mask 2'b01, out_ready=11 ->
  - Output 1 sees only 0x01; output 0 sees only 0x03.
  - 0x02 is accepted without any out_valid.
- Reset mid-operation: P=2'b11 held with out_ready=0, pulse rst one cycle -> out_valid=0 and busy=0 next cycle, no transfer of the held beat, in_ready=1.
- Random stimulus with scoreboard: random in_valid, mask, and out_ready over 10k cycles -> per-output received sequence equals input beats filtered by mask; valid/data hold checked on every stalled cycle.
